// File: rtl/clock_seg_scan.sv
// Six-digit multiplexed seven-segment scanner for hh:mm:ss with per-frame snapshot and
// one blank cycle per slot. Optional decimal-point blink is enabled by defining DP_BLINK_EN.
module clock_seg_scan #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] sec,
    input  logic [7:0] minute,
    input  logic [7:0] hour,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);

    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  snap_s_q, snap_s_d;
    logic [7:0]  snap_m_q, snap_m_d;
    logic [7:0]  snap_h_q, snap_h_d;
    logic [6:0]  seg_q, seg_d;
    logic [5:0]  an_q, an_d;

    logic [7:0]  field;
    logic [7:0]  digit;
    logic        over;

    function automatic logic [6:0] seg_decode(input logic [7:0] d);
        logic [6:0] s;
        case (d)
            8'd0:    s = 7'h3F;
            8'd1:    s = 7'h06;
            8'd2:    s = 7'h5B;
            8'd3:    s = 7'h4F;
            8'd4:    s = 7'h66;
            8'd5:    s = 7'h6D;
            8'd6:    s = 7'h7D;
            8'd7:    s = 7'h07;
            8'd8:    s = 7'h7F;
            8'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Prescaler, slot index and the once-per-frame snapshot.
    always_comb begin
        pre_d    = pre_q + 16'd1;
        idx_d    = idx_q;
        snap_s_d = snap_s_q;
        snap_m_d = snap_m_q;
        snap_h_d = snap_h_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        if (pre_q == '0 && idx_q == '0) begin
            snap_s_d = sec;
            snap_m_d = minute;
            snap_h_d = hour;
        end
    end

    // Digit selection; odd slots carry the tens digit of their field.
    always_comb begin
        field = snap_s_q;
        over  = snap_s_q > 8'd59;
        case (idx_q)
            3'd2, 3'd3: begin
                field = snap_m_q;
                over  = snap_m_q > 8'd59;
            end
            3'd4, 3'd5: begin
                field = snap_h_q;
                over  = snap_h_q > 8'd23;
            end
            default: ;
        endcase
        digit = idx_q[0] ? (field / 8'd10) : (field % 8'd10);
        seg_d = over ? 7'h40 : seg_decode(digit);
        an_d  = (pre_q == '0) ? 6'b000000 : (6'b000001 << idx_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q    <= '0;
            idx_q    <= '0;
            snap_s_q <= '0;
            snap_m_q <= '0;
            snap_h_q <= '0;
            seg_q    <= '0;
            an_q     <= '0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            snap_s_q <= snap_s_d;
            snap_m_q <= snap_m_d;
            snap_h_q <= snap_h_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

`ifdef DP_BLINK_EN
    logic dp_q, dp_d;

    // Separators after minute and hour digits, lit on even seconds only.
    always_comb begin
        dp_d = (idx_q == 3'd2 || idx_q == 3'd4) && (pre_q != '0) && !snap_s_q[0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_q <= 1'b0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_clock_seg_scan.sv
// Bench for clock_seg_scan with SCAN_DIV=4: directed literal frames plus randomized
// inputs and resets checked every cycle against a cycle-count based reference model.
module tb_clock_seg_scan;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] sec = 8'd0;
    logic [7:0] minute = 8'd0;
    logic [7:0] hour = 8'd0;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;

    int total = 0;
    int bad = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    clock_seg_scan #(.SCAN_DIV(D)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sec    (sec),
        .minute (minute),
        .hour   (hour),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since release, and the snapshot visible to each edge.
    int          k_q;
    logic [23:0] cap_q;
    logic [23:0] disp_q;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k_q    <= 0;
            cap_q  <= '0;
            disp_q <= '0;
        end else begin
            k_q    <= k_q + 1;
            disp_q <= cap_q;
            if (k_q % (6 * D) == 0) cap_q <= {hour, minute, sec};
        end
    end

    function automatic logic [6:0] exp_seg(input logic [23:0] snap, input int idx);
        int v;
        int lim;
        case (idx / 2)
            0:       begin v = int'(snap[7:0]);   lim = 59; end
            1:       begin v = int'(snap[15:8]);  lim = 59; end
            default: begin v = int'(snap[23:16]); lim = 23; end
        endcase
        if (v > lim) return 7'h40;
        return seg_tab[(idx % 2 == 1) ? v / 10 : v % 10];
    endfunction

    always @(negedge clk) begin : cmp
        int kk;
        int pre;
        int idx;
        int e_an;
        int e_dp;
        if (!resetn || k_q == 0) begin
            chk("seg_rst", seg, 0);
            chk("an_rst", an, 0);
            chk("dp_rst", dp, 0);
        end else begin
            kk   = k_q - 1;
            pre  = kk % D;
            idx  = (kk / D) % 6;
            e_an = (pre == 0) ? 0 : (1 << idx);
`ifdef DP_BLINK_EN
            e_dp = ((idx == 2 || idx == 4) && pre != 0 && disp_q[0] == 1'b0) ? 1 : 0;
`else
            e_dp = 0;
`endif
            chk("an_model", an, e_an);
            chk("seg_model", seg, exp_seg(disp_q, idx));
            chk("dp_model", dp, e_dp);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_and_release();
        @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour   = 8'(h);
        minute = 8'(m);
        sec    = 8'(s);
    endtask

    // Walks one frame from release, checking the literal digit sequence;
    // optionally changes sec during slot 3 (value 0 disables).
    task automatic frame_literals(input logic [6:0] lit [6], input int new_sec);
        wait_edges(1);
        chk("an_edge1", an, 0);
        wait_edges(1);
        for (int n = 0; n < 6; n++) begin
            chk("lit_seg", seg, lit[n]);
            chk("lit_an", an, 1 << n);
            if (n == 3 && new_sec != 0) sec = 8'(new_sec);
            wait_edges(3);
            chk("lit_blank", an, 0);
            wait_edges(1);
        end
    endtask

    task automatic dp_frame(input int s, input logic [5:0] mask);
        set_time(12, 34, s);
        reset_and_release();
        wait_edges(2);
        for (int n = 0; n < 6; n++) begin
            chk("dp_lit", dp, int'(mask[n]));
            wait_edges(D);
        end
    endtask

    logic [6:0] lit_a [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [6:0] lit_b [6] = '{7'h6F, 7'h6D, 7'h40, 7'h40, 7'h40, 7'h40};

    initial begin
        #1 resetn = 1'b0;

        // Reset and first frame, then snapshot coherence.
        set_time(12, 34, 56);
        reset_and_release();
        frame_literals(lit_a, 57);
        chk("next_frame_seg", seg, 7'h07);
        chk("next_frame_an", an, 1);

        // Out-of-range fields.
        set_time(24, 60, 59);
        reset_and_release();
        frame_literals(lit_b, 0);

        // Reset between edges in slot 3 must clear outputs without a clock.
        set_time(12, 34, 56);
        reset_and_release();
        wait_edges(14);
        chk("pre_async_an", an, 6'b001000);
        #2 resetn = 1'b0;
        #1;
        chk("async_seg", seg, 0);
        chk("async_an", an, 0);
        chk("async_dp", dp, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        frame_literals(lit_a, 0);

`ifdef DP_BLINK_EN
        dp_frame(10, 6'b010100);
`else
        dp_frame(10, 6'b000000);
`endif
        dp_frame(11, 6'b000000);

        // Randomized inputs and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) sec    = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) minute = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) hour   = 8'($urandom_range(0, 27));
            if ($urandom_range(0, 299) == 0) begin
                #2 resetn = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                resetn = 1'b1;
            end
        end

        wait_edges(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
